mem_interface_unit: RTL and testbench
=====================================

# mem_interface_unit

Word-addressed memory port between a core pipeline stage (instruction fetch or data access) and a local on-chip memory array. It accepts one read or write request per cycle. Read data returns one cycle later, tagged with its request address so the consumer can realign its PC or address. It is instantiated once per port per core and is identified in diagnostics by its `CORE` parameter.

## Interface
Parameters:
- `CORE`, 0 — core ID, used only in report output.
- `DATA_WIDTH`, 32 — word width.
- `INDEX_BITS`, 6 — index field width; memory depth is 2^(INDEX_BITS+OFFSET_BITS) words.
- `OFFSET_BITS`, 3 — offset field width; 512 words at the defaults.
- `ADDRESS_BITS`, 20 — word-address width.

Ports:
- `clock`  in  1  — sole clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `read`  in  1  — read request.
- `write`  in  1  — write request.
- `address`  in  ADDRESS_BITS  — word address of the request.
- `in_data`  in  DATA_WIDTH  — write data.
- `out_addr`  out  ADDRESS_BITS  — address of the word currently on `out_data`.
- `out_data`  out  DATA_WIDTH  — read data.
- `valid`  out  1  — `out_data` and `out_addr` hold a completed read this cycle.
- `ready`  out  1  — a request is accepted at the next rising edge.
- `report`  in  1  — print a status dump this cycle (see Configuration).

## Operation
- Storage is an array of 2^(INDEX_BITS+OFFSET_BITS) words of DATA_WIDTH bits. It is indexed by `address[INDEX_BITS+OFFSET_BITS-1:0]`.
- Upper address bits are ignored, so addresses wrap modulo the depth. `out_addr` still returns the full, unmodified `address`.
- A request is accepted at a rising edge when `ready`=1 and at least one of `read` or `write` is 1.
- A request presented while `ready`=0 is dropped. The requester must hold it until `ready`=1.
- Accepted write: `mem[index] <= in_data`. `valid` is not asserted for a write.
- Accepted read: the word is registered into `out_data` and `address` into `out_addr`. `valid` goes to 1 for the following cycle.
- Simultaneous `read`=1 and `write`=1: the write is performed and the read is discarded. `valid`=0 on the next cycle.
- Read after write to the same address on the next cycle returns the new data.
- No-request cycle: `valid` falls to 0. `out_data` and `out_addr` hold their last values.
- Back-to-back reads: one result per cycle, in request order, with `valid` continuously 1.
- Memory contents are not cleared by reset. Contents are undefined until written.

## Timing
- Reset asserted (`reset`=0, asynchronous):
  - `valid`=0, `ready`=0, `out_data`=0, `out_addr`=0 immediately.
  - Any in-flight read is cancelled and produces no `valid`.
- First rising edge after `reset` returns to 1: `ready` becomes 1. No request is accepted at that edge.
- From then on `ready` stays 1 until the next reset.
- Read latency is exactly 1 cycle. A request accepted at edge N gives `valid`=1 with data from edge N until edge N+1.
- Throughput is 1 request per cycle.
- Write latency: the array is updated at the accepting edge.

## Configuration
- Macro `MEM_INTERFACE_REPORT_EN`.
- Defined:
  - A free-running cycle counter is kept. It is cleared by reset and increments every clock.
  - On each rising edge with `report`=1, one block is printed showing `CORE`, the cycle count, `read`, `write`, `address`, `in_data`, `out_addr`, `out_data`, `valid` and `ready`.
- Undefined:
  - The counter and all display code are compiled out.
  - `report` is ignored.
  - Functional behaviour is identical.

## Test plan
- Reset held low for 3 cycles, then released → `valid`=0, `ready`=0, `out_data`=0 while reset is low; `ready`=1 one edge after release.
- Write 0xDEADBEEF to addr 0x005, then read 0x005 on the next cycle → one cycle later `valid`=1, `out_data`=0xDEADBEEF, `out_addr`=0x005.
- Write 0x11111111 to 0x003 and 0x22222222 to 0x004, then read 0x003 and 0x004 back-to-back → `valid`=1 for two consecutive cycles, with `out_data` 0x11111111 then 0x22222222.
- Read addr 0x00203 after writing 0xCAFE0001 to 0x003 → `out_data`=0xCAFE0001 (wrap at 512 words), `out_addr`=0x00203.
- `read`=1 and `write`=1 together at 0x010 with `in_data`=0x5A5A5A5A → `valid`=0 the next cycle; a subsequent read of 0x010 returns 0x5A5A5A5A.
- Read issued, then `reset` driven low before the next edge → `valid` never asserts; all outputs are 0.

Source files
------------

// File: rtl/mem_interface_unit.sv
// mem_interface_unit
//
// Word-addressed port between one core pipeline stage and a local on-chip
// memory array. It accepts one read or write per cycle. Read data comes back
// one cycle later, tagged with the full request address.
//
// Build option: define MEM_INTERFACE_REPORT_EN to compile in a free-running
// cycle counter and a per-edge status dump gated by the `report` input.
// Without the macro, the counter and the dump are absent, `report` is ignored,
// and the functional behaviour is unchanged.
//
// Handshake (valid/ready):
//   - ready : the port accepts a request at the next rising edge. A request
//             is read=1 or write=1 while ready=1. Requests presented while
//             ready=0 are dropped, so the requester holds them until ready=1.
//   - valid : out_data/out_addr hold a read completed at the previous edge.
//             It is asserted for exactly one cycle per accepted read, never
//             for a write, and it has no back-pressure.
//   - read and write together in one request perform the write and discard
//     the read.

module mem_interface_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_BITS   = 6,
    parameter int OFFSET_BITS  = 3,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [ADDRESS_BITS-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    valid,
    output logic                    ready,
    input  logic                    report
);

    // Storage geometry. Upper address bits beyond DEPTH_BITS are ignored, so
    // the array wraps modulo its depth.
    localparam int DEPTH_BITS = INDEX_BITS + OFFSET_BITS;
    localparam int DEPTH      = 1 << DEPTH_BITS;

    // Port control state. After reset the port spends one edge in ST_WAKE
    // (not ready). It then moves to ST_RUN and stays there until the next
    // reset. The state_q register is the observable state for checkers.
    typedef enum logic {
        ST_WAKE = 1'b0,
        ST_RUN  = 1'b1
    } port_state_e;

    port_state_e state_q;
    port_state_e state_d;

    // Request decode
    logic                  accept;
    logic                  do_write;
    logic                  do_read;
    logic [DEPTH_BITS-1:0] mem_index;

    // Storage array. It is deliberately not reset, and its contents are
    // undefined until written.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Registered read result
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDRESS_BITS-1:0] raddr_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register: reset forces the port back to the not-ready wake state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAKE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and ready decode: wake lasts exactly one edge, then run forever
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_WAKE: begin
                ready   = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                ready   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                ready   = 1'b0;
                state_d = ST_WAKE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------

    // Accept only while ready. Write wins over a simultaneous read.
    always_comb begin
        accept    = 1'b0;
        do_write  = 1'b0;
        do_read   = 1'b0;
        mem_index = address[DEPTH_BITS-1:0];
        if (ready && (read || write)) begin
            accept = 1'b1;
        end
        if (accept && write) begin
            do_write = 1'b1;
        end
        if (accept && read && !write) begin
            do_read = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage and read path
    // ------------------------------------------------------------------

    // Array write at the accepting edge, so a read on the next edge sees it
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[mem_index] <= in_data;
        end
    end

    // Read result register: valid pulses per read, data/addr hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            raddr_q <= '0;
        end else begin
            valid_q <= do_read;
            if (do_read) begin
                rdata_q <= mem[mem_index];
                raddr_q <= address;
            end
        end
    end

    assign valid    = valid_q;
    assign out_data = rdata_q;
    assign out_addr = raddr_q;

    // ------------------------------------------------------------------
    // Diagnostics
    // ------------------------------------------------------------------

`ifdef MEM_INTERFACE_REPORT_EN
    logic [31:0] cycle_count;

    // Free-running cycle counter, cleared by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Status dump on every edge where report is asserted
    always @(posedge clock) begin
        if (report) begin
            $display("[mem_interface_unit core %0d] cycle=%0d", CORE, cycle_count);
            $display("  read=%0b write=%0b address=%0h in_data=%0h",
                     read, write, address, in_data);
            $display("  out_addr=%0h out_data=%0h valid=%0b ready=%0b",
                     out_addr, out_data, valid, ready);
        end
    end
`else
    // report and CORE only feed the optional dump
    logic unused_ok;
    assign unused_ok = &{1'b0, report, (CORE != 0)};
`endif

endmodule

// File: tb/tb_mem_interface_unit.sv
// Testbench for mem_interface_unit: directed scenarios plus a random mix.
// A bench-side reference memory supplies the expected read data, and the
// expected {addr, data} is queued when a read is driven. A monitor pops and
// compares the queue on every valid cycle.

module tb_mem_interface_unit;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] in_data;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          valid;
    logic          ready;
    logic          report;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    model_mem [int];

    mem_interface_unit #(
        .CORE         (0),
        .DATA_WIDTH   (DW),
        .INDEX_BITS   (6),
        .OFFSET_BITS  (3),
        .ADDRESS_BITS (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .read     (read),
        .write    (write),
        .address  (address),
        .in_data  (in_data),
        .out_addr (out_addr),
        .out_data (out_data),
        .valid    (valid),
        .ready    (ready),
        .report   (report)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] actual,
                            input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one request for one edge. Update the model or queue the expectation.
    task automatic req(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        read    = r;
        write   = w;
        address = a;
        in_data = d;
        if (w) begin
            model_mem[int'(a[8:0])] = d;
        end else if (r) begin
            exp_q.push_back({a, model_mem[int'(a[8:0])]});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        read  = 1'b0;
        write = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(valid), 64'd0);
        check_eq({tag, "_ready"}, 64'(ready), 64'd0);
        check_eq({tag, "_data"}, 64'(out_data), 64'd0);
        check_eq({tag, "_addr"}, 64'(out_addr), 64'd0);
    endtask

    // Scoreboard monitor: every valid cycle must match the oldest expectation
    initial begin
        logic [AW+DW-1:0] exp;
        forever begin
            @(negedge clock);
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 64'(valid), 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check_eq("rd_addr", 64'(out_addr), 64'(exp[AW+DW-1:DW]));
                    check_eq("rd_data", 64'(out_data), 64'(exp[DW-1:0]));
                end
            end
        end
    end

    // Main stimulus
    initial begin
        logic [AW-1:0] a;
        int            op;

        reset   = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        address = '0;
        in_data = '0;
        report  = 1'b0;

        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clock);
            check_zero_outputs("rst");
        end
        reset = 1'b1;
        // A write presented at the wake edge must be dropped
        write   = 1'b1;
        address = 20'h020;
        in_data = 32'h0BAD0BAD;
        @(posedge clock);
        #1;
        check_eq("wake_ready", 64'(ready), 64'd1);
        check_eq("wake_no_valid", 64'(valid), 64'd0);
        req(0, 1, 20'h020, 32'h600D600D);
        req(1, 0, 20'h020, 32'h0);

        // Write then read next cycle
        req(0, 1, 20'h005, 32'hDEADBEEF);
        check_eq("wr_no_valid", 64'(valid), 64'd0);
        req(1, 0, 20'h005, 32'h0);
        idle();
        check_eq("idle_valid", 64'(valid), 64'd0);
        check_eq("hold_data", 64'(out_data), 64'hDEADBEEF);
        check_eq("hold_addr", 64'(out_addr), 64'h005);

        // Back-to-back reads
        req(0, 1, 20'h003, 32'h11111111);
        req(0, 1, 20'h004, 32'h22222222);
        req(1, 0, 20'h003, 32'h0);
        check_eq("b2b_valid0", 64'(valid), 64'd1);
        req(1, 0, 20'h004, 32'h0);
        check_eq("b2b_valid1", 64'(valid), 64'd1);
        idle();

        // Address wrap at 512 words
        req(0, 1, 20'h003, 32'hCAFE0001);
        req(1, 0, 20'h00203, 32'h0);
        idle();

        // Simultaneous read and write: write wins, no valid
        req(1, 1, 20'h010, 32'h5A5A5A5A);
        check_eq("rw_no_valid", 64'(valid), 64'd0);
        req(1, 0, 20'h010, 32'h0);
        idle();

        // Random mix. Reads only target words the model already holds.
        report = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 2));
            a  = {11'($urandom_range(0, 2047)), 9'($urandom_range(0, 15))};
            if (op == 1 && !model_mem.exists(int'(a[8:0]))) begin
                op = 0;
            end
            case (op)
                0: req(0, 1, a, 32'($urandom));
                1: req(1, 0, a, 32'h0);
                default: idle();
            endcase
            report = 1'b0;
        end
        idle();
        idle();

        // Reset before the accepting edge: the read is never accepted
        @(negedge clock);
        read    = 1'b1;
        address = 20'h007;
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("rst_pre");
        @(posedge clock);
        #1;
        check_zero_outputs("rst_hold");
        read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rel2_ready", 64'(ready), 64'd1);

        // Reset while a read result is on the outputs: cleared immediately
        read    = 1'b1;
        address = 20'h005;
        @(posedge clock);
        #1;
        check_eq("pre_rst_valid", 64'(valid), 64'd1);
        read  = 1'b0;
        reset = 1'b0;
        #1;
        check_zero_outputs("rst_async");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rel3_ready", 64'(ready), 64'd1);

        // Memory contents survive reset
        req(1, 0, 20'h005, 32'h0);
        req(1, 0, 20'h003, 32'h0);
        idle();
        idle();

        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
